fixed_point_dispatcher: RTL and testbench
=========================================

# fixed_point_dispatcher

Request sequencer directly upstream of the fixed-point unit. Accepts one arithmetic request at a time from the execute stage over a valid/ready handshake and holds the operands and operation code stable on the unit's inputs. It waits for the unit's level-sensitive `ready`, captures the result, and presents it to writeback over a second valid/ready handshake. It masks stale `ready` levels left over from a previous multi-cycle operation and, optionally, aborts hung operations.

## Interface
- `WIDTH`, 32: operand/result width.
- `SETTLE_CYCLES`, 2: cycles after issue during which `fpu_ready` is ignored; range 1-15.
- `TIMEOUT_CYCLES`, 255: WAIT-state cycle limit. Used only with the timeout feature; range 1-65535.

Ports:
- `clk` in 1: clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `in_valid` in 1: request present.
- `in_ready` out 1: dispatcher can accept a request.
- `in_operation` in 2: `FPU_ADD`/`FPU_SUB`/`FPU_MUL`/`FPU_SQRT` code from Defines.vh.
- `in_operand_1` in WIDTH: first operand.
- `in_operand_2` in WIDTH: second operand; ignored for SQRT.
- `fpu_operation` out 2: operation code driven to the unit.
- `fpu_operand_1` out WIDTH: first operand driven to the unit.
- `fpu_operand_2` out WIDTH: second operand driven to the unit.
- `fpu_result` in WIDTH: unit result.
- `fpu_ready` in 1: unit result valid (level).
- `out_valid` out 1: result available to writeback.
- `out_ready` in 1: writeback accepts the result.
- `out_result` out WIDTH: captured result.
- `out_error` out 1: result produced by timeout abort; tied 0 without the timeout feature.
- `busy` out 1: high in any state other than IDLE.

## Operation
- States:
  - IDLE: `in_ready`=1.
  - ISSUE: settle countdown.
  - WAIT: sample `fpu_ready`.
  - DONE: `out_valid`=1.
- IDLE: on `in_valid & in_ready`, latch operation and both operands into the `fpu_*` registers, load the settle counter with `SETTLE_CYCLES`, go to ISSUE.
- ISSUE: decrement the settle counter each cycle. At 1, go to WAIT. `fpu_ready` is ignored throughout ISSUE.
- WAIT: on `fpu_ready`=1, capture `fpu_result` into `out_result`, clear `out_error`, go to DONE.
- DONE: hold `out_result` and `out_error`. On `out_ready`, go to IDLE.
  - No new request is accepted in the same cycle as the DONE handshake; `in_ready` rises the following cycle.
- The `fpu_*` outputs stay constant from ISSUE until the next accepted request. They keep the last request's values while IDLE.
- SQRT: `fpu_operand_2` is loaded with 0.
- Operands and the result pass through unmodified; no width conversion or rounding.
- `in_valid` while not IDLE is ignored; no queuing. Upstream must hold the request until `in_ready`.
- Reset (asynchronous, at any time, including mid-operation):
  - State goes to IDLE.
  - `fpu_operation`=`FPU_ADD`; `fpu_operand_1`, `fpu_operand_2` and `out_result` = 0.
  - `out_valid`=0, `out_error`=0, `busy`=0, `in_ready`=1.
  - Counters cleared; any in-flight result is discarded.

## Timing
- Request accepted at edge N → ISSUE from N to N+`SETTLE_CYCLES`. The earliest WAIT sample is at edge N+`SETTLE_CYCLES`+1.
- ADD/SUB: result captured at edge N+`SETTLE_CYCLES`+1. `out_valid` is high from that edge, i.e. 3 cycles after acceptance at default settings.
- MUL/SQRT: `out_valid` rises one edge after the first WAIT-cycle `fpu_ready`=1.
- `out_valid` stays high until the `out_ready` handshake, regardless of later `fpu_ready` changes.
- Minimum request-to-request spacing: `SETTLE_CYCLES`+3 cycles with `out_ready` held high.

## Configuration
- Macro: `FPU_DISPATCH_TIMEOUT_EN`.
- Defined:
  - A 16-bit WAIT counter is cleared on entry to WAIT and increments each WAIT cycle.
  - When it reaches `TIMEOUT_CYCLES` without `fpu_ready`: go to DONE with `out_result`=0 and `out_error`=1.
  - If `fpu_ready` and the timeout coincide, `fpu_ready` wins (normal result, `out_error`=0).
- Undefined:
  - No counter; WAIT holds indefinitely.
  - `out_error` is constant 0.

## Test plan
- Reset: assert `reset`=0 mid-WAIT → next cycle `busy`=0, `in_ready`=1, `out_valid`=0, `out_result`=0, `out_error`=0. Release, then issue ADD 0x600+0x800 → result 0xE00.
- Back-to-back ADD then SUB (1.5, 2.0; WIDTH 32, FBITS 10), `out_ready`=1:
  - ADD: `out_result`=0x00000E00, `out_valid` 3 cycles after acceptance.
  - SUB: `out_result`=0xFFFFFE00.
  - `in_ready` low throughout each operation.
- Stale-ready masking: MUL 0x600×0x800 with a unit model holding `fpu_ready`=1 from the previous op and dropping it after 1 cycle, then raising it 6 cycles later → single `out_result`=0x00000C00. No early capture.
- Backpressure: SQRT 0x1000 with `out_ready`=0 for 10 cycles → `out_valid` and `out_result`=0x00000800 held stable; `in_valid` pulses during DONE are ignored. Raise `out_ready` → `in_ready` returns one cycle later.
- Timeout (macro defined, `TIMEOUT_CYCLES`=8): `fpu_ready` never asserts → `out_valid` with `out_result`=0, `out_error`=1.
  - `fpu_ready` rising on the 8th WAIT cycle instead → normal result, `out_error`=0.
- Timeout (macro undefined): `fpu_ready` held 0 for 1000 cycles → `busy`=1, `out_valid`=0 throughout.

Source files
------------

// File: rtl/fixed_point_dispatcher_if.sv
// Request, unit-drive and writeback signals of the fixed-point dispatcher.
// slave: dispatcher view; master: execute stage / unit / writeback view.
interface fixed_point_dispatcher_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_operation;
  logic [WIDTH-1:0] in_operand_1;
  logic [WIDTH-1:0] in_operand_2;
  logic [1:0]       fpu_operation;
  logic [WIDTH-1:0] fpu_operand_1;
  logic [WIDTH-1:0] fpu_operand_2;
  logic [WIDTH-1:0] fpu_result;
  logic             fpu_ready;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_error;
  logic             busy;

  modport slave (
    input  in_valid, in_operation, in_operand_1, in_operand_2,
    input  fpu_result, fpu_ready, out_ready,
    output in_ready, fpu_operation, fpu_operand_1, fpu_operand_2,
    output out_valid, out_result, out_error, busy
  );

  modport master (
    output in_valid, in_operation, in_operand_1, in_operand_2,
    output fpu_result, fpu_ready, out_ready,
    input  in_ready, fpu_operation, fpu_operand_1, fpu_operand_2,
    input  out_valid, out_result, out_error, busy
  );
endinterface

// File: rtl/fixed_point_dispatcher.sv
// Sequences one request at a time into the fixed-point unit and hands the result to writeback.
// Optional hung-operation abort is enabled by defining FPU_DISPATCH_TIMEOUT_EN.
module fixed_point_dispatcher #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned SETTLE_CYCLES  = 2,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  fixed_point_dispatcher_if.slave bus
);
  localparam int unsigned SETTLE_W = 4;
  localparam int unsigned WAIT_W   = 16;
  localparam logic [1:0]  FPU_ADD  = 2'd0;
  localparam logic [1:0]  FPU_SQRT = 2'd3;

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $error("SETTLE_CYCLES out of range 1-15");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES out of range 1-65535");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t              state;
  logic [SETTLE_W-1:0] settle_cnt;

`ifdef FPU_DISPATCH_TIMEOUT_EN
  logic [WAIT_W-1:0] wait_cnt;
  logic              out_error_q;
  assign bus.out_error = out_error_q;
`else
  assign bus.out_error = 1'b0;
`endif

  // Sequencer: all status outputs are registered alongside the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state             <= S_IDLE;
      settle_cnt        <= '0;
      bus.fpu_operation <= FPU_ADD;
      bus.fpu_operand_1 <= '0;
      bus.fpu_operand_2 <= '0;
      bus.out_result    <= '0;
      bus.out_valid     <= 1'b0;
      bus.in_ready      <= 1'b1;
      bus.busy          <= 1'b0;
`ifdef FPU_DISPATCH_TIMEOUT_EN
      wait_cnt          <= '0;
      out_error_q       <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid && bus.in_ready) begin
            bus.fpu_operation <= bus.in_operation;
            bus.fpu_operand_1 <= bus.in_operand_1;
            bus.fpu_operand_2 <= (bus.in_operation == FPU_SQRT) ? WIDTH'(0) : bus.in_operand_2;
            settle_cnt        <= SETTLE_W'(SETTLE_CYCLES);
            bus.in_ready      <= 1'b0;
            bus.busy          <= 1'b1;
            state             <= S_ISSUE;
          end
        end
        // fpu_ready may still be high from the previous operation; ignore it here.
        S_ISSUE: begin
          if (settle_cnt == SETTLE_W'(1)) begin
            state <= S_WAIT;
`ifdef FPU_DISPATCH_TIMEOUT_EN
            wait_cnt <= '0;
`endif
          end else begin
            settle_cnt <= settle_cnt - SETTLE_W'(1);
          end
        end
        S_WAIT: begin
          if (bus.fpu_ready) begin
            bus.out_result <= bus.fpu_result;
            bus.out_valid  <= 1'b1;
            state          <= S_DONE;
`ifdef FPU_DISPATCH_TIMEOUT_EN
            out_error_q    <= 1'b0;
          end else if (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
            bus.out_result <= WIDTH'(0);
            bus.out_valid  <= 1'b1;
            out_error_q    <= 1'b1;
            state          <= S_DONE;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
`endif
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            bus.busy      <= 1'b0;
            state         <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fixed_point_dispatcher.sv
// Scoreboard bench for fixed_point_dispatcher: directed requests push expected results,
// a negedge monitor pops and compares on every writeback handshake.
module tb_fixed_point_dispatcher;
  localparam logic [1:0] OP_ADD  = 2'd0;
  localparam logic [1:0] OP_SUB  = 2'd1;
  localparam logic [1:0] OP_MUL  = 2'd2;
  localparam logic [1:0] OP_SQRT = 2'd3;

  typedef struct packed {
    logic [31:0] result;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  exp_t sb[$];

  fixed_point_dispatcher_if #(.WIDTH(32)) bus ();

  fixed_point_dispatcher #(
    .WIDTH(32),
    .SETTLE_CYCLES(2),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int acc_cyc);
    bus.in_operation = op;
    bus.in_operand_1 = a;
    bus.in_operand_2 = b;
    bus.in_valid     = 1'b1;
    for (int k = 0; k < 64; k++) begin
      if (bus.in_ready) break;
      step(1);
    end
    chk("accept_in_ready", 32'(bus.in_ready), 32'd1);
    step(1);
    bus.in_valid = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic wait_valid(input int max_cycles);
    for (int k = 0; k < max_cycles; k++) begin
      if (bus.out_valid) break;
      step(1);
    end
    chk("out_valid_arrives", 32'(bus.out_valid), 32'd1);
  endtask

  // Monitor: every writeback handshake must match the oldest expected entry.
  always @(negedge clk) begin
    if (reset && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", bus.out_result, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_result", bus.out_result, e.result);
        chk("sb_error", 32'(bus.out_error), 32'(e.err));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, got cycle %0d expected below 5000", cyc);
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, t;
    logic bad;
    reset = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_operation = OP_ADD;
    bus.in_operand_1 = '0;
    bus.in_operand_2 = '0;
    bus.fpu_result = '0;
    bus.fpu_ready = 1'b0;
    bus.out_ready = 1'b1;
    step(2);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_result", bus.out_result, 32'd0);
    chk("rst_fpu_op1", bus.fpu_operand_1, 32'd0);
    reset = 1'b1;
    step(1);

    // Back-to-back ADD then SUB, unit answering immediately.
    bus.fpu_ready  = 1'b1;
    bus.fpu_result = 32'h0000_0E00;
    sb.push_back('{32'h0000_0E00, 1'b0});
    issue(OP_ADD, 32'h600, 32'h800, t0);
    chk("add_in_ready_low", 32'(bus.in_ready), 32'd0);
    chk("add_busy", 32'(bus.busy), 32'd1);
    chk("add_fpu_op1", bus.fpu_operand_1, 32'h600);
    chk("add_fpu_op2", bus.fpu_operand_2, 32'h800);
    step(2);
    chk("add_no_early_valid", 32'(bus.out_valid), 32'd0);
    chk("add_in_ready_mid", 32'(bus.in_ready), 32'd0);
    step(1);
    chk("add_valid_lat3", 32'(bus.out_valid), 32'd1);
    chk("add_in_ready_done", 32'(bus.in_ready), 32'd0);
    step(1);
    chk("add_in_ready_back", 32'(bus.in_ready), 32'd1);
    bus.fpu_result = 32'hFFFF_FE00;
    sb.push_back('{32'hFFFF_FE00, 1'b0});
    issue(OP_SUB, 32'h600, 32'h800, t1);
    chk("b2b_spacing", 32'(t1 - t0), 32'd5);
    wait_valid(10);
    step(1);

    // Stale fpu_ready from the SUB must not be captured for the MUL.
    sb.push_back('{32'h0000_0C00, 1'b0});
    issue(OP_MUL, 32'h600, 32'h800, t);
    step(1);
    bus.fpu_ready = 1'b0;
    bad = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step(1);
      if (bus.out_valid) bad = 1'b1;
    end
    chk("mul_no_early_capture", 32'(bad), 32'd0);
    bus.fpu_ready  = 1'b1;
    bus.fpu_result = 32'h0000_0C00;
    step(1);
    chk("mul_valid", 32'(bus.out_valid), 32'd1);
    chk("mul_result", bus.out_result, 32'h0000_0C00);
    step(1);
    bus.fpu_ready = 1'b0;

    // SQRT under writeback backpressure with ignored in_valid pulses.
    bus.out_ready  = 1'b0;
    bus.fpu_result = 32'h0000_0800;
    sb.push_back('{32'h0000_0800, 1'b0});
    issue(OP_SQRT, 32'h1000, 32'h1234, t);
    chk("sqrt_op2_zero", bus.fpu_operand_2, 32'd0);
    chk("sqrt_opcode", 32'(bus.fpu_operation), 32'(OP_SQRT));
    step(2);
    bus.fpu_ready = 1'b1;
    step(1);
    chk("sqrt_valid", 32'(bus.out_valid), 32'd1);
    bus.fpu_result = 32'h0000_0BAD;
    bad = 1'b0;
    for (int k = 0; k < 10; k++) begin
      bus.in_valid = k[0];
      bus.in_operation = OP_ADD;
      bus.in_operand_1 = 32'h1;
      bus.in_operand_2 = 32'h2;
      bus.fpu_ready = k[1];
      step(1);
      if (!(bus.out_valid && bus.out_result == 32'h800 && !bus.in_ready &&
            bus.fpu_operand_1 == 32'h1000)) bad = 1'b1;
    end
    bus.in_valid  = 1'b0;
    bus.fpu_ready = 1'b0;
    chk("bp_hold_stable", 32'(bad), 32'd0);
    bus.out_ready = 1'b1;
    chk("bp_in_ready_during_hs", 32'(bus.in_ready), 32'd0);
    step(1);
    chk("bp_in_ready_after", 32'(bus.in_ready), 32'd1);
    chk("bp_out_valid_after", 32'(bus.out_valid), 32'd0);
    chk("idle_keeps_op1", bus.fpu_operand_1, 32'h1000);

    // Asynchronous reset while waiting on the unit; the in-flight result is dropped.
    bus.fpu_result = 32'h0000_0E00;
    issue(OP_ADD, 32'h600, 32'h800, t);
    step(3);
    reset = 1'b0;
    step(1);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_out_result", bus.out_result, 32'd0);
    chk("mid_rst_out_error", 32'(bus.out_error), 32'd0);
    chk("mid_rst_fpu_op1", bus.fpu_operand_1, 32'd0);
    reset = 1'b1;
    step(1);
    bus.fpu_ready = 1'b1;
    sb.push_back('{32'h0000_0E00, 1'b0});
    issue(OP_ADD, 32'h600, 32'h800, t);
    wait_valid(10);
    chk("post_rst_result", bus.out_result, 32'h0000_0E00);
    step(1);
    bus.fpu_ready = 1'b0;

`ifdef FPU_DISPATCH_TIMEOUT_EN
    // Unit never answers: abort after 8 WAIT cycles.
    bus.fpu_result = 32'h0000_0C00;
    sb.push_back('{32'h0, 1'b1});
    issue(OP_MUL, 32'h600, 32'h800, t);
    step(9);
    chk("to_not_yet", 32'(bus.out_valid), 32'd0);
    step(1);
    chk("to_valid", 32'(bus.out_valid), 32'd1);
    chk("to_error", 32'(bus.out_error), 32'd1);
    chk("to_result", bus.out_result, 32'd0);
    step(1);
    // Ready on the 8th WAIT cycle beats the timeout.
    sb.push_back('{32'h0000_0C00, 1'b0});
    issue(OP_MUL, 32'h600, 32'h800, t);
    step(9);
    bus.fpu_ready = 1'b1;
    step(1);
    chk("to_race_valid", 32'(bus.out_valid), 32'd1);
    chk("to_race_error", 32'(bus.out_error), 32'd0);
    step(1);
    bus.fpu_ready = 1'b0;
`else
    // Without the abort feature a silent unit keeps the dispatcher busy indefinitely.
    issue(OP_MUL, 32'h600, 32'h800, t);
    bad = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      step(1);
      if (!(bus.busy && !bus.out_valid && !bus.out_error)) bad = 1'b1;
    end
    chk("hang_busy_no_valid", 32'(bad), 32'd0);
    reset = 1'b0;
    step(1);
    chk("hang_rst_busy", 32'(bus.busy), 32'd0);
    reset = 1'b1;
    step(1);
`endif

    step(3);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
